seq_mult_n: RTL and testbench
=============================

Name: seq_mult_n

Overview:
Parametrised unsigned shift-add multiplier. It is the sequential successor to the fixed 4x4 array multiplier.
- One partial-product row (A AND replicated B bit) is generated and accumulated per clock.
- Area is traded for WIDTH-cycle latency.
- A start/busy/done handshake lets a controller or testbench issue operations back-to-back.

Parameters:
- WIDTH, 4, operand width in bits; legal values are 2..32. The product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), step-counter width. This is derived; callers do not override it.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when idle
- A  in  WIDTH  multiplicand, unsigned
- B  in  WIDTH  multiplier, unsigned
- P  out  2*WIDTH  product, registered
- busy  out  1  high while a multiply is in progress
- done  out  1  one-cycle pulse; P is valid from this cycle onward

Behaviour:
- Reset (rst_n=0, async, takes effect immediately):
  - state=IDLE, P=0, busy=0, done=0.
  - Internal accumulator, operand registers and counter are cleared to 0.
- States:
  - IDLE: waits for start.
  - RUN: performs WIDTH accumulate/shift steps.
- IDLE, start=1 at edge E0:
  - Latch a_reg<=A and b_reg<=B.
  - Clear acc (2*WIDTH bits); cnt<=0.
  - busy<=1, done<=0, go to RUN.
  - Operands are sampled only at E0. Changes to A/B afterwards have no effect.
- RUN, each edge:
  - pp = a_reg AND {WIDTH{b_reg[0]}}.
  - acc <= acc + (pp << cnt), using 2*WIDTH-bit arithmetic. No overflow is possible.
  - b_reg <= b_reg >> 1; cnt <= cnt+1.
- RUN, edge where cnt==WIDTH-1 (edge E0+WIDTH):
  - P <= final acc value, including this step's add.
  - done<=1, busy<=0, go to IDLE.
- Latency: done is high in the cycle after edge E0+WIDTH, i.e. WIDTH cycles after the start edge.
- done is high for exactly one cycle, then returns to 0.
- P holds its value until the next completion or a reset. P does not change at start or during RUN.
- Throughput: start may be asserted in the done cycle and is accepted there, giving one result per WIDTH+1 cycles.
- start while busy=1 is ignored: no relatch, no restart, no error flag.
- start held high continuously produces consecutive operations, each on the A/B present at its accept edge.
- Early termination is not implemented. B=0 or A=0 still takes WIDTH cycles and gives P=0.
- Reset asserted mid-RUN aborts the operation: P=0, no done pulse. After release the block idles until the next start.
- No combinational path from inputs to outputs. busy equals (state==RUN).

Decomposition:
- Shared package (mult_pkg) holds:
  - state enum {IDLE, RUN}
  - default WIDTH constant
  - function prod_w(w)=2*w
- One sub-module: pp_and_row #(WIDTH).
  - Combinational, Y = A AND {WIDTH{b}}.
  - This is the parametrised generalisation of the 4-bit AND row, and is reused by future array/Booth variants.
- FSM, counter and accumulator stay in seq_mult_n.

Test Plan:
1. WIDTH=4, A=13, B=11, one-cycle start → busy=1 for 4 cycles; done pulses in cycle 4 after start; P=8'h8F (143); P stays 143 for 10 further idle cycles.
2. WIDTH=4, A=15, B=15, then A=0, B=9 issued in the done cycle → P=225 (8'hE1) at first done, then P=0 at second done exactly 5 cycles later; P stays 225 between the two done pulses.
3. WIDTH=4, A=6, B=7 start; two cycles later start with A=3, B=3 → second start ignored; single done with P=42; no further done.
4. WIDTH=4, A=9, B=5 start; rst_n low for 1 cycle at cycle 2 → P=0, busy=0, done=0 immediately; no done for 10 cycles; a new start with A=2, B=3 gives P=6.
5. WIDTH=8, A=255, B=255 → done 8 cycles after start, P=16'hFE01 (65025). Then randomised 1000 back-to-back ops compared against a reference model of A*B.
6. A/B changed every cycle during RUN after a start with A=12, B=10 → P=120, proving operands are latched at accept.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the multiplier family.
package mult_pkg;

    // Operand width used when the caller does not override it.
    localparam int unsigned DEFAULT_WIDTH = 4;

    // Controller states.
    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    // Product width for a given operand width.
    function automatic int unsigned prod_w(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/pp_and_row.sv
// One partial-product row: every multiplicand bit gated by a single multiplier bit.
module pp_and_row #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             b_i,
    output logic [WIDTH-1:0] y_o
);

    // Gate the whole row with the replicated multiplier bit.
    always_comb begin
        y_o = a_i & {WIDTH{b_i}};
    end

endmodule

// File: rtl/seq_mult_n.sv
// Unsigned shift-add multiplier: one partial-product row accumulated per clock,
// WIDTH clocks per product, with a start/busy/done handshake.
module seq_mult_n
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [WIDTH-1:0]          A,
    input  logic [WIDTH-1:0]          B,
    output logic [prod_w(WIDTH)-1:0]  P,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned PW    = prod_w(WIDTH);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    p_q, p_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] pp;
    logic [PW-1:0]    pp_ext;
    logic [PW-1:0]    acc_sum;

    pp_and_row #(
        .WIDTH (WIDTH)
    ) u_pp_row (
        .a_i (a_q),
        .b_i (b_q[0]),
        .y_o (pp)
    );

    // Weight the current row by its step index; 2*WIDTH bits cannot overflow.
    always_comb begin
        pp_ext  = {{WIDTH{1'b0}}, pp};
        acc_sum = acc_q + (pp_ext << cnt_q);
    end

    // Next-state logic: accept in idle, accumulate and shift in run.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = acc_sum;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Publish the sum including this final step's row.
                    p_d     = acc_sum;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        P    = p_q;
        done = done_q;
        busy = (state_q == StRun);
    end

endmodule

// File: tb/tb_seq_mult_n.sv
// Directed checks of seq_mult_n at WIDTH=4 and WIDTH=8, plus back-to-back random ops.
module tb_seq_mult_n;

    logic        clk;
    logic        rst_n;

    logic        start4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    logic        busy4, done4;

    logic        start8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        busy8, done8;

    int total;
    int bad;

    seq_mult_n #(
        .WIDTH (4)
    ) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .A     (a4),
        .B     (b4),
        .P     (p4),
        .busy  (busy4),
        .done  (done4)
    );

    seq_mult_n #(
        .WIDTH (8)
    ) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .P     (p8),
        .busy  (busy8),
        .done  (done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] exp8;
        total  = 0;
        bad    = 0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        rst_n  = 1'b0;

        // Reset state
        #12;
        check("rst_p4", 64'(p4), 64'h0);
        check("rst_busy4", 64'(busy4), 64'h0);
        check("rst_done4", 64'(done4), 64'h0);
        check("rst_p8", 64'(p8), 64'h0);
        rst_n = 1'b1;
        tick();

        // 1: 13*11 = 143, busy for 4 cycles, then P holds
        a4 = 4'd13; b4 = 4'd11; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t1_busy", 64'(busy4), 64'h1);
            check("t1_nodone", 64'(done4), 64'h0);
            check("t1_p_run", 64'(p4), 64'h0);
            tick();
        end
        check("t1_done", 64'(done4), 64'h1);
        check("t1_busy_end", 64'(busy4), 64'h0);
        check("t1_p", 64'(p4), 64'h8F);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t1_done_low", 64'(done4), 64'h0);
            check("t1_p_hold", 64'(p4), 64'h8F);
        end

        // 2: 15*15 then 0*9 issued in the done cycle
        a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (3) tick();
        tick();
        check("t2_done1", 64'(done4), 64'h1);
        check("t2_p1", 64'(p4), 64'hE1);
        a4 = 4'd0; b4 = 4'd9; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("t2_busy2", 64'(busy4), 64'h1);
        check("t2_p_keep", 64'(p4), 64'hE1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t2_nodone", 64'(done4), 64'h0);
            check("t2_p_keep", 64'(p4), 64'hE1);
        end
        tick();
        check("t2_done2", 64'(done4), 64'h1);
        check("t2_p2", 64'(p4), 64'h00);
        tick();
        check("t2_pulse", 64'(done4), 64'h0);

        // 3: start while busy is ignored
        a4 = 4'd6; b4 = 4'd7; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        a4 = 4'd3; b4 = 4'd3; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        check("t3_done", 64'(done4), 64'h1);
        check("t3_p", 64'(p4), 64'd42);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t3_no_extra", 64'(done4), 64'h0);
            check("t3_p_hold", 64'(p4), 64'd42);
        end

        // 4: reset mid-run aborts
        a4 = 4'd9; b4 = 4'd5; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t4_rst_p", 64'(p4), 64'h0);
        check("t4_rst_busy", 64'(busy4), 64'h0);
        check("t4_rst_done", 64'(done4), 64'h0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t4_idle_done", 64'(done4), 64'h0);
            check("t4_idle_busy", 64'(busy4), 64'h0);
        end
        a4 = 4'd2; b4 = 4'd3; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (3) tick();
        tick();
        check("t4_done", 64'(done4), 64'h1);
        check("t4_p", 64'(p4), 64'd6);

        // 6: operand changes during run have no effect
        a4 = 4'd12; b4 = 4'd10; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            tick();
        end
        a4 = 4'd1; b4 = 4'd1;
        tick();
        check("t6_done", 64'(done4), 64'h1);
        check("t6_p", 64'(p4), 64'd120);

        // 5: WIDTH=8 corner, then back-to-back random ops
        a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("t5_nodone", 64'(done8), 64'h0);
        end
        tick();
        check("t5_done", 64'(done8), 64'h1);
        check("t5_p", 64'(p8), 64'hFE01);
        for (int n = 0; n < 1000; n++) begin
            // Issued in the previous done cycle so operations run back to back.
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            start8 = 1'b1;
            exp8 = 16'(a8) * 16'(b8);
            tick();
            start8 = 1'b0;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            repeat (7) tick();
            tick();
            check("t5_rand_done", 64'(done8), 64'h1);
            check("t5_rand_p", 64'(p8), 64'(exp8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
